// File: rtl/ahb_traffic_master.sv
// ahb_traffic_master: AHB-Lite master that writes INCR bursts over an address window,
// reads them back, compares against the written pattern and flags bus errors.
module ahb_traffic_master #(
    parameter int HADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int HPROT_WIDTH = 4,
    parameter logic [HADDR_WIDTH-1:0] BASE_ADDR = 'h4003_0000,
    parameter int ADDR_SPAN = 256,
    parameter int BURST_LEN = 4,
    parameter int NUM_BURSTS = 8
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   seed,
    input  logic                    hready,
    input  logic [DATA_WIDTH-1:0]   hrdata,
    input  logic                    hresp,
    output logic [HADDR_WIDTH-1:0]  haddr,
    output logic [1:0]              htrans,
    output logic                    hwrite,
    output logic [2:0]              hsize,
    output logic [2:0]              hburst,
    output logic [HPROT_WIDTH-1:0]  hprot,
    output logic                    hmasterlock,
    output logic [DATA_WIDTH-1:0]   hwdata,
    output logic [DATA_WIDTH/8-1:0] hwstrb,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             mismatch_cnt
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(ADDR_SPAN);
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [1:0] HT_IDLE = 2'b00, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11;

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t state, state_n;
    logic [BW-1:0] beat, beat_n;
    logic [31:0] burst_cnt, burst_cnt_n;
    logic [OFFW-1:0] off, off_n;
    logic [DATA_WIDTH-1:0] pat, pat_n, exp_d, exp_n, hwdata_n;
    logic [HADDR_WIDTH-1:0] haddr_n;
    logic [1:0] htrans_n;
    logic hwrite_n, dph, dph_n, dph_wr, dph_wr_n, abort, abort_n, err_n, more;
    logic [15:0] mcnt_n;

    assign hsize = 3'($clog2(BPB));
    assign hburst = (BURST_LEN == 4) ? 3'd3 : (BURST_LEN == 8) ? 3'd5 : 3'd7;
    assign hprot = HPROT_WIDTH'(4'b0011);
    assign hmasterlock = 1'b0;
    assign hwstrb = '1;

    always_comb begin
        state_n = state;
        beat_n = beat;
        burst_cnt_n = burst_cnt;
        off_n = off;
        pat_n = pat;
        exp_n = exp_d;
        hwdata_n = hwdata;
        haddr_n = haddr;
        htrans_n = htrans;
        hwrite_n = hwrite;
        dph_n = dph;
        dph_wr_n = dph_wr;
        abort_n = abort;
        err_n = err;
        mcnt_n = mismatch_cnt;
        more = (NUM_BURSTS == 0) ? start : (burst_cnt + 32'd1 < 32'(NUM_BURSTS));
        case (state)
            IDLE: if (start) begin
                state_n = WR;
                beat_n = '0;
                burst_cnt_n = '0;
                off_n = '0;
                pat_n = seed;
                haddr_n = BASE_ADDR;
                htrans_n = HT_NONSEQ;
                hwrite_n = 1'b1;
                abort_n = 1'b0;
                err_n = 1'b0;
                mcnt_n = '0;
            end
            WR, RD: if (abort) begin
                if (hready) begin
                    state_n = DONE;
                    dph_n = 1'b0;
                    abort_n = 1'b0;
                end
            end else if (dph && hresp && !hready) begin
                // first error cycle: cancel the pending address phase
                abort_n = 1'b1;
                err_n = 1'b1;
                htrans_n = HT_IDLE;
            end else if (hready) begin
                dph_n = 1'b0;
                if (dph && !dph_wr && !hresp && hrdata != exp_d && mismatch_cnt != '1)
                    mcnt_n = mismatch_cnt + 16'd1;
                if (htrans[1]) begin
                    dph_n = 1'b1;
                    dph_wr_n = hwrite;
                    exp_n = pat + DATA_WIDTH'(beat);
                    if (hwrite) hwdata_n = exp_n;
                    beat_n = beat + 1'b1;
                    if (beat != BW'(BURST_LEN - 1)) begin
                        htrans_n = HT_SEQ;
                        haddr_n = haddr + HADDR_WIDTH'(BPB);
                    end else if (state == WR) begin
                        state_n = RD;
                        htrans_n = HT_NONSEQ;
                        hwrite_n = 1'b0;
                        haddr_n = BASE_ADDR + HADDR_WIDTH'(off);
                    end else begin
                        burst_cnt_n = burst_cnt + 32'd1;
                        off_n = off + OFFW'(BURST_LEN * BPB);
                        pat_n = pat + DATA_WIDTH'(BURST_LEN);
                        haddr_n = BASE_ADDR + HADDR_WIDTH'(off_n);
                        htrans_n = more ? HT_NONSEQ : HT_IDLE;
                        hwrite_n = more;
                        state_n = more ? WR : RD;
                    end
                end else if (state == RD) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= IDLE;
            beat <= '0;
            burst_cnt <= '0;
            off <= '0;
            pat <= '0;
            exp_d <= '0;
            hwdata <= '0;
            haddr <= BASE_ADDR;
            htrans <= HT_IDLE;
            hwrite <= 1'b0;
            dph <= 1'b0;
            dph_wr <= 1'b0;
            abort <= 1'b0;
            err <= 1'b0;
            mismatch_cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            beat <= beat_n;
            burst_cnt <= burst_cnt_n;
            off <= off_n;
            pat <= pat_n;
            exp_d <= exp_n;
            hwdata <= hwdata_n;
            haddr <= haddr_n;
            htrans <= htrans_n;
            hwrite <= hwrite_n;
            dph <= dph_n;
            dph_wr <= dph_wr_n;
            abort <= abort_n;
            err <= err_n;
            mismatch_cnt <= mcnt_n;
            busy <= (state_n == WR) || (state_n == RD);
            done <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_ahb_traffic_master.sv
// tb_ahb_traffic_master: directed vectors against a small memory slave with
// injectable wait states, read corruption and two-cycle error responses.
module tb_ahb_traffic_master;
    localparam logic [31:0] BASE = 32'h4003_0000;
    localparam int NB = 5, BL = 4, NX = 2 * BL * NB;

    logic hclk = 0, hresetn = 0, start = 0, clr = 0;
    logic [31:0] seed = 0;
    logic hready, hresp;
    logic [31:0] hrdata, haddr, hwdata;
    logic [1:0] htrans;
    logic hwrite, hmasterlock, busy, done, err;
    logic [2:0] hsize, hburst;
    logic [3:0] hprot, hwstrb;
    logic [15:0] mismatch_cnt;

    ahb_traffic_master #(.BASE_ADDR(BASE), .ADDR_SPAN(64), .BURST_LEN(BL), .NUM_BURSTS(NB)) dut (
        .hclk(hclk), .hresetn(hresetn), .start(start), .seed(seed), .hready(hready),
        .hrdata(hrdata), .hresp(hresp), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmasterlock(hmasterlock),
        .hwdata(hwdata), .hwstrb(hwstrb), .busy(busy), .done(done), .err(err),
        .mismatch_cnt(mismatch_cnt)
    );

    always #5 hclk = ~hclk;

    // memory slave: 16 words covering the 64-byte window
    logic [31:0] mem [16];
    logic dp_act, dp_wr;
    logic [31:0] dp_addr;
    logic [1:0] err_st;
    int dp_no, beat_no, wait_left, n_acc, n_d;
    int err_beat = 1000, corrupt_no = 1000;
    bit wait_on = 0;
    logic [31:0] log_addr [64];
    logic [31:0] log_d [64];
    logic log_wr [64];

    assign hready = !dp_act || (wait_left == 0 && err_st != 2'd1);
    assign hresp = dp_act && err_st != 2'd0;
    assign hrdata = mem[dp_addr[5:2]] ^ {31'b0, dp_act && !dp_wr && dp_no == corrupt_no};

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_act <= 0; dp_wr <= 0; dp_addr <= 0; dp_no <= 0;
            err_st <= 0; wait_left <= 0; beat_no <= 0; n_acc <= 0; n_d <= 0;
        end else if (clr) begin
            beat_no <= 0; n_acc <= 0; n_d <= 0;
        end else if (hready) begin
            if (dp_act && err_st == 2'd0) begin
                if (dp_wr) mem[dp_addr[5:2]] <= hwdata;
                if (n_d < 64) log_d[n_d] <= dp_wr ? hwdata : hrdata;
                n_d <= n_d + 1;
            end
            err_st <= 0;
            if (htrans[1]) begin
                dp_act <= 1; dp_wr <= hwrite; dp_addr <= haddr; dp_no <= beat_no;
                if (n_acc < 64) begin log_addr[n_acc] <= haddr; log_wr[n_acc] <= hwrite; end
                n_acc <= n_acc + 1;
                beat_no <= beat_no + 1;
                wait_left <= (wait_on && beat_no % 3 == 2) ? 2 : 0;
                err_st <= (beat_no == err_beat) ? 2'd1 : 2'd0;
            end else begin
                dp_act <= 0;
            end
        end else if (err_st == 2'd1) begin
            err_st <= 2'd2;
        end else if (wait_left != 0) begin
            wait_left <= wait_left - 1;
        end
    end

    // stall stability and second-error-cycle observation
    bit stall_prev = 0, e2_seen = 0;
    int st_chk = 0, st_bad = 0;
    logic [66:0] prev_bus;
    logic [1:0] e2_tr = 2'b11;
    always @(negedge hclk) begin
        if (stall_prev) begin
            st_chk <= st_chk + 1;
            if ({haddr, htrans, hwrite, hwdata} != prev_bus) st_bad <= st_bad + 1;
        end
        stall_prev <= hresetn && !hready && !hresp;
        prev_bus <= {haddr, htrans, hwrite, hwdata};
        if (hresp && hready) begin e2_seen <= 1; e2_tr <= htrans; end
    end

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } vec_t;
    vec_t tbl [2][NX];
    logic [31:0] sd [2];
    logic [31:0] a, d;
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] s, output int cyc);
        @(negedge hclk); start = 1; seed = s; clr = 1;
        @(negedge hclk); start = 0; clr = 0;
        chk("start_busy", 96'(busy), 96'(1));
        chk("start_htrans", 96'(htrans), 96'(2));
        chk("start_haddr", 96'(haddr), 96'(BASE));
        cyc = 0;
        while (!done && cyc < 600) begin @(negedge hclk); cyc++; end
        chk("done_seen", 96'(done), 96'(1));
        chk("busy_at_done", 96'(busy), 96'(0));
        @(negedge hclk);
        chk("done_pulse", 96'(done), 96'(0));
    endtask

    task automatic check_table(input int t, input string tag);
        chk({tag, "_nacc"}, 96'(n_acc), 96'(NX));
        chk({tag, "_ndata"}, 96'(n_d), 96'(NX));
        for (int i = 0; i < NX; i++)
            chk($sformatf("%s_xfer%0d", tag, i), {log_addr[i], 31'b0, log_wr[i], log_d[i]},
                {tbl[t][i].addr, 31'b0, tbl[t][i].wr, tbl[t][i].data});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        sd[0] = 32'h100;
        sd[1] = 32'hFFFF_FFFE;
        for (int t = 0; t < 2; t++)
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < BL; k++) begin
                    a = BASE + 32'((b * 16) % 64) + 32'(k * 4);
                    d = sd[t] + 32'(b * BL + k);
                    tbl[t][b * 8 + k] = '{a, 1'b1, d};
                    tbl[t][b * 8 + 4 + k] = '{a, 1'b0, d};
                end

        repeat (3) @(negedge hclk);
        chk("rst_haddr", 96'(haddr), 96'(BASE));
        chk("rst_htrans", 96'(htrans), 96'(0));
        chk("rst_busy_done_err", 96'({busy, done, err, hwrite}), 96'(0));
        chk("rst_hwdata_mcnt", {hwdata, mismatch_cnt}, 96'(0));
        hresetn = 1;
        @(negedge hclk);
        chk("const_hsize_hburst", 96'({hsize, hburst}), 96'({3'd2, 3'd3}));
        chk("const_hprot_lock_strb", 96'({hprot, hmasterlock, hwstrb}), 96'({4'b0011, 1'b0, 4'hF}));

        // zero-wait run: 5 bursts, burst 4 wraps back to the window base
        run(sd[0], cyc);
        chk("zw_cycles", 96'(cyc), 96'(NX + 1));
        check_table(0, "zw");
        chk("zw_w7_addr", 96'(log_addr[11]), 96'(32'h4003_001C));
        chk("zw_w7_data", 96'(log_d[11]), 96'(32'h107));
        chk("zw_wrap_addr", 96'(log_addr[32]), 96'(BASE));
        chk("zw_wrap_data", 96'(log_d[32]), 96'(32'h110));
        chk("zw_mcnt_err", 96'({mismatch_cnt, err}), 96'(0));

        // two wait cycles on every third beat, seed crossing the 2^32 boundary
        wait_on = 1;
        run(sd[1], cyc);
        wait_on = 0;
        chk("ws_cycles", 96'(cyc), 96'(NX + 1 + 26));
        check_table(1, "ws");
        chk("ws_stall_checks", 96'(st_chk), 96'(26));
        chk("ws_stall_stable", 96'(st_bad), 96'(0));
        chk("ws_mcnt_err", 96'({mismatch_cnt, err}), 96'(0));

        // one corrupted read word
        corrupt_no = 6;
        run(sd[0], cyc);
        corrupt_no = 1000;
        chk("cr_cycles", 96'(cyc), 96'(NX + 1));
        chk("cr_mcnt", 96'(mismatch_cnt), 96'(1));
        chk("cr_err", 96'(err), 96'(0));

        // error response on write beat 2 of burst 0
        err_beat = 2;
        run(sd[0], cyc);
        err_beat = 1000;
        chk("er_cycles", 96'(cyc), 96'(5));
        chk("er_err", 96'(err), 96'(1));
        chk("er_second_cycle_seen", 96'(e2_seen), 96'(1));
        chk("er_second_cycle_htrans", 96'(e2_tr), 96'(0));
        repeat (5) @(negedge hclk);
        chk("er_no_more_xfers", 96'(n_acc), 96'(3));
        chk("er_idle_after", 96'({htrans, busy}), 96'(0));

        // asynchronous reset mid-burst, then a fresh run
        @(negedge hclk); start = 1; seed = sd[0]; clr = 1;
        @(negedge hclk); start = 0; clr = 0;
        chk("mr_err_cleared", 96'(err), 96'(0));
        repeat (5) @(negedge hclk);
        chk("mr_busy_before", 96'(busy), 96'(1));
        #2 hresetn = 0;
        #1;
        chk("mr_haddr", 96'(haddr), 96'(BASE));
        chk("mr_htrans_hwrite", 96'({htrans, hwrite}), 96'(0));
        chk("mr_hwdata", 96'(hwdata), 96'(0));
        chk("mr_flags", 96'({busy, done, err, mismatch_cnt}), 96'(0));
        @(negedge hclk);
        hresetn = 1;
        run(sd[1], cyc);
        chk("mr_cycles", 96'(cyc), 96'(NX + 1));
        check_table(1, "mr");
        chk("mr_mcnt_err", 96'({mismatch_cnt, err}), 96'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_traffic_master.md
# ahb_traffic_master

Parametrised AHB-Lite traffic-generating master for SoC bring-up and interconnect stress. It issues write/read-back INCR bursts over a configurable address window, compares read data against the written pattern and reports mismatches and bus errors. It connects in place of a CPU master port on the interconnect. Unlike the fixed-pattern core model it replaces, it has:
- correct address/data-phase pipelining;
- configurable burst length and count;
- two-cycle error-response handling;
- a start/done handshake.

## Interface
- HADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (32 or 64)
- HPROT_WIDTH, 4, hprot width
- BASE_ADDR, 32'h4003_0000, window base; must be aligned to ADDR_SPAN
- ADDR_SPAN, 256, window size in bytes; power of two, ≤1024, multiple of BURST_LEN*DATA_WIDTH/8
- BURST_LEN, 4, beats per burst; one of 4/8/16
- NUM_BURSTS, 8, write+read burst pairs per run; 0 = run until start is deasserted
- hclk  in  1  clock
- hresetn  in  1  reset; asynchronous, active-low
- start  in  1  run request; sampled only when idle
- seed  in  DATA_WIDTH  pattern seed; sampled with start
- hready  in  1  interconnect ready
- hrdata  in  DATA_WIDTH  read data
- hresp  in  1  error response
- haddr  out  HADDR_WIDTH  address
- htrans  out  2  IDLE=0, NONSEQ=2, SEQ=3 (BUSY never issued)
- hwrite  out  1  write
- hsize  out  3  log2(DATA_WIDTH/8)
- hburst  out  3  INCR4=3, INCR8=5, INCR16=7, per BURST_LEN
- hprot  out  HPROT_WIDTH  constant 4'b0011
- hmasterlock  out  1  constant 0
- hwdata  out  DATA_WIDTH  write data
- hwstrb  out  DATA_WIDTH/8  constant all ones
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- err  out  1  sticky; bus error seen
- mismatch_cnt  out  16  read-compare failures; saturating

## Operation
- **States:** IDLE, WR, RD, DONE.
- **IDLE → WR** on start=1. Latch seed, clear err and mismatch_cnt, set burst_idx=0.
- **Burst base address:** BASE_ADDR + ((burst_idx*BURST_LEN*BPB) mod ADDR_SPAN), where BPB = DATA_WIDTH/8. The window wraps to BASE_ADDR; a burst never crosses the window or a 1 KB boundary.
- **WR:** issues BURST_LEN beats. Beat 0 is NONSEQ, later beats SEQ, haddr increments by BPB, hwrite=1.
  - Write data for beat k = seed + burst_idx*BURST_LEN + k (mod 2^DATA_WIDTH).
  - hwdata is driven in that beat's data phase.
- **WR → RD** when the last write address phase is accepted. RD issues the same addresses with hwrite=0.
- **Read check:** each read data phase completing (hready=1) compares hrdata with the expected value; a mismatch increments mismatch_cnt (saturates at 16'hFFFF).
- **RD → next burst:** when the last read address phase is accepted, burst_idx increments.
  - Go to WR if burst_idx < NUM_BURSTS.
  - With NUM_BURSTS=0, go to WR if start=1.
  - Otherwise go to DONE once the final data phase completes.
- **DONE:** pulse done for one cycle, then return to IDLE.
- **Error response:** hresp=1 with hready=0 at a clock edge → htrans=IDLE in the next cycle (the second error cycle).
  - Set err, abandon the remaining beats and pairs, go to DONE after the second error cycle.
  - No compare is performed for an errored read.
- start while busy is ignored.
- Reset mid-run returns immediately to the reset values below; no bus cleanup is performed.

## Timing
- **Reset values:** haddr=BASE_ADDR, htrans=IDLE, hwrite=0, hwdata=0, busy=0, done=0, err=0, mismatch_cnt=0. Constant outputs hold their constant values.
- All outputs are registered except the constants.
- **Run start:** start sampled at edge T → busy=1 and htrans=NONSEQ from T+1.
- **Address/data handshake:**
  - The address phase holds haddr/htrans/hwrite stable while hready=0.
  - The data phase starts on the edge where the address is accepted (hready=1).
  - hwdata holds stable until its data phase completes.
- **Zero-wait slave:**
  - One burst pair takes 2*BURST_LEN address cycles back to back; the read NONSEQ overlaps the last write data phase.
  - done pulses one cycle after the last read data phase completes; busy falls in the same cycle as done.
- **Wait states:** each wait cycle delays all subsequent phases by exactly one cycle.

## Test plan
- **Zero-wait run:** BURST_LEN=4, NUM_BURSTS=2, seed=0x100, zero-wait memory slave → 16 transfers.
  - Writes to 0x40030000–0x4003001C with data 0x100–0x107, then matching reads.
  - done after the last read; mismatch_cnt=0, err=0.
- **Window wrap:** NUM_BURSTS=5, ADDR_SPAN=64, BURST_LEN=4 → burst 4 base wraps to 0x40030000.
- **Wait states:** hready=0 for 2 cycles on every 3rd beat → haddr/hwdata held stable during waits; total cycles increase by exactly the inserted waits; mismatch_cnt=0.
- **Corrupted read:** slave corrupts one read word → mismatch_cnt=1, err=0, run completes normally.
- **Write error:** two-cycle ERROR on write beat 2 of burst 0 → htrans=IDLE in the second error cycle, err=1, done pulses, no further transfers.
- **Reset mid-burst:** hresetn asserted mid-burst → all outputs at reset values asynchronously; after release, a new start restarts from BASE_ADDR.
